// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I ID stage: ALU operations, opcodes, funct fields and the ID/EX
// payload.
package decode_stage_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } aluCtrl_e;

   typedef enum logic [6:0] {
      OPC_OP     = 7'b0110011,
      OPC_OP_IMM = 7'b0010011,
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_BRANCH = 7'b1100011,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111
   } opcode_e;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_ZERO = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef struct packed {
      logic [31:0] pc;
      aluCtrl_e    alu_ctrl;
      logic        src_pc;
      logic        src_imm;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        illegal;
   } idex_t;

   localparam idex_t IDEX_CLEAR = '{
      pc:        32'h0,
      alu_ctrl:  ALU_ADD,
      src_pc:    1'b0,
      src_imm:   1'b0,
      imm:       32'h0,
      rs1:       5'd0,
      rs2:       5'd0,
      rd:        5'd0,
      reg_write: 1'b0,
      illegal:   1'b0
   };

   // Shared OP / OP-IMM funct3 map; alt selects SUB/SRA from funct7[5].
   function automatic aluCtrl_e f3_to_alu(input logic [2:0] f3, input logic alt);
      aluCtrl_e w_op;
      unique case (f3)
         F3_ADD_SUB: w_op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     w_op = ALU_SLL;
         F3_SLT:     w_op = ALU_SLT;
         F3_SLTU:    w_op = ALU_SLTU;
         F3_XOR:     w_op = ALU_XOR;
         F3_SR:      w_op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      w_op = ALU_OR;
         default:    w_op = ALU_AND;
      endcase
      return w_op;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF->ID and ID->EX handshake/payload bundle; slave is the decode stage's view.
interface decode_stage_if;
   import decode_stage_pkg::*;

   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   aluCtrl_e    ex_alu_ctrl;
   logic        ex_src_pc;
   logic        ex_src_imm;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_illegal;

   modport slave (
      input  if_valid, if_instr, if_pc, flush, ex_ready,
      output if_ready, ex_valid, ex_pc, ex_alu_ctrl, ex_src_pc, ex_src_imm, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_illegal
   );

   modport master (
      output if_valid, if_instr, if_pc, flush, ex_ready,
      input  if_ready, ex_valid, ex_pc, ex_alu_ctrl, ex_src_pc, ex_src_imm, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_illegal
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode, sign-extended from
// instr[31]; OP-IMM shifts yield the zero-extended shamt.
module decode_stage_imm_gen
   import decode_stage_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [31:0] o_imm
);

   logic [2:0] w_f3;
   assign w_f3 = i_instr[14:12];

   always_comb begin
      o_imm = 32'h0;
      case (i_instr[6:0])
         OPC_OP_IMM: begin
            if (w_f3 == F3_SLL || w_f3 == F3_SR) begin
               o_imm = {27'h0, i_instr[24:20]};
            end else begin
               o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            end
         end
         OPC_LOAD, OPC_JALR: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
         OPC_STORE:          o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         OPC_BRANCH: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                              i_instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC: o_imm = {i_instr[31:12], 12'h0};
         OPC_JAL: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
         default: o_imm = 32'h0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: combinational decode into an idex_t payload held in the ID/EX register,
// with valid/ready on both sides and a flush that kills the register contents.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter bit CLEAR_ON_FLUSH = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   decode_stage_if.slave  bus
);

   logic [31:0] w_instr;
   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm;
   logic        w_ill;
   logic        w_wr;
   logic        w_if_ready;
   idex_t       w_dec;

   idex_t       r_idex;
   logic        r_valid;

   assign w_instr  = bus.if_instr;
   assign w_opcode = w_instr[6:0];
   assign w_f3     = w_instr[14:12];
   assign w_f7     = w_instr[31:25];

   decode_stage_imm_gen u_imm_gen (
      .i_instr (w_instr),
      .o_imm   (w_imm)
   );

   always_comb begin
      w_dec     = IDEX_CLEAR;
      w_ill     = 1'b0;
      w_wr      = 1'b0;
      w_dec.pc  = bus.if_pc;
      w_dec.rs1 = w_instr[19:15];
      w_dec.rs2 = w_instr[24:20];
      w_dec.rd  = w_instr[11:7];
      case (w_opcode)
         OPC_OP: begin
            if (w_f7 == F7_ZERO ||
                (w_f7 == F7_ALT && (w_f3 == F3_ADD_SUB || w_f3 == F3_SR))) begin
               w_dec.alu_ctrl = f3_to_alu(w_f3, w_f7[5]);
               w_wr           = 1'b1;
            end else begin
               w_ill = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            w_dec.src_imm = 1'b1;
            w_wr          = 1'b1;
            // funct7 only matters for shifts; ADDI must never become SUB.
            if (w_f3 == F3_SLL) begin
               w_ill = (w_f7 != F7_ZERO);
            end else if (w_f3 == F3_SR) begin
               w_ill = !(w_f7 == F7_ZERO || w_f7 == F7_ALT);
            end
            w_dec.alu_ctrl = f3_to_alu(w_f3, (w_f3 == F3_SR) && w_f7[5]);
         end
         OPC_LUI: begin
            w_dec.alu_ctrl = ALU_LUI;
            w_dec.src_imm  = 1'b1;
            w_wr           = 1'b1;
         end
         OPC_AUIPC, OPC_JAL: begin
            w_dec.src_pc  = 1'b1;
            w_dec.src_imm = 1'b1;
            w_wr          = 1'b1;
         end
         OPC_LOAD: begin
            w_dec.src_imm = 1'b1;
            w_wr          = 1'b1;
         end
         OPC_STORE: begin
            w_dec.src_imm = 1'b1;
         end
         OPC_BRANCH: begin
            unique case (w_f3)
               F3_BEQ, F3_BNE:   w_dec.alu_ctrl = ALU_SUB;
               F3_BLT, F3_BGE:   w_dec.alu_ctrl = ALU_SLT;
               F3_BLTU, F3_BGEU: w_dec.alu_ctrl = ALU_SLTU;
               default:          w_ill = 1'b1;
            endcase
         end
         OPC_JALR: begin
            if (w_f3 == 3'b000) begin
               w_dec.src_imm = 1'b1;
               w_wr          = 1'b1;
            end else begin
               w_ill = 1'b1;
            end
         end
         default: w_ill = 1'b1;
      endcase

      // Any illegal encoding collapses to one canonical harmless payload.
      if (w_ill) begin
         w_dec.alu_ctrl  = ALU_ADD;
         w_dec.src_pc    = 1'b0;
         w_dec.src_imm   = 1'b0;
         w_dec.imm       = 32'h0;
         w_dec.reg_write = 1'b0;
      end else begin
         w_dec.imm       = w_imm;
         w_dec.reg_write = w_wr && (w_dec.rd != 5'd0);
      end
      w_dec.illegal = w_ill;
   end

   assign w_if_ready = !r_valid || bus.ex_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_idex  <= IDEX_CLEAR;
      end else if (bus.flush) begin
         r_valid <= 1'b0;
         if (CLEAR_ON_FLUSH) begin
            r_idex <= IDEX_CLEAR;
         end
      end else if (w_if_ready) begin
         if (bus.if_valid) begin
            r_valid <= 1'b1;
            r_idex  <= w_dec;
         end else begin
            r_valid <= 1'b0;
            if (CLEAR_ON_FLUSH) begin
               r_idex <= IDEX_CLEAR;
            end
         end
      end
   end

   assign bus.if_ready     = w_if_ready;
   assign bus.ex_valid     = r_valid;
   assign bus.ex_pc        = r_idex.pc;
   assign bus.ex_alu_ctrl  = r_idex.alu_ctrl;
   assign bus.ex_src_pc    = r_idex.src_pc;
   assign bus.ex_src_imm   = r_idex.src_imm;
   assign bus.ex_imm       = r_idex.imm;
   assign bus.ex_rs1       = r_idex.rs1;
   assign bus.ex_rs2       = r_idex.rs2;
   assign bus.ex_rd        = r_idex.rd;
   assign bus.ex_reg_write = r_idex.reg_write;
   assign bus.ex_illegal   = r_idex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instruction vectors with hand-computed payloads,
// plus stall, bubble, flush and asynchronous reset scenarios.
module tb_decode_stage;
   import decode_stage_pkg::*;

   typedef struct {
      idex_t e;
      string name;
   } sb_t;

   typedef struct {
      logic [31:0] ins;
      idex_t       e;
      string       name;
   } vec_t;

   logic   clk;
   logic   rst;
   int     n_tests;
   int     n_fail;
   logic   m_valid;
   idex_t  exp_cur;
   string  name_cur;
   idex_t  zero_p;
   sb_t    sbq[$];
   vec_t   vecs[$];

   decode_stage_if bus ();

   decode_stage #(
      .CLEAR_ON_FLUSH (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic idex_t mk(input aluCtrl_e a, input logic sp, input logic si,
                                input logic [31:0] imm, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] rd,
                                input logic rw, input logic ill);
      idex_t p;
      p.pc        = 32'h0;
      p.alu_ctrl  = a;
      p.src_pc    = sp;
      p.src_imm   = si;
      p.imm       = imm;
      p.rs1       = r1;
      p.rs2       = r2;
      p.rd        = rd;
      p.reg_write = rw;
      p.illegal   = ill;
      return p;
   endfunction

   function automatic string fmt(input idex_t p);
      return $sformatf("pc=%h alu=%0d sp=%b si=%b imm=%h rs1=%0d rs2=%0d rd=%0d rw=%b ill=%b",
                       p.pc, p.alu_ctrl, p.src_pc, p.src_imm, p.imm, p.rs1, p.rs2, p.rd,
                       p.reg_write, p.illegal);
   endfunction

   function automatic idex_t actual();
      idex_t p;
      p.pc        = bus.ex_pc;
      p.alu_ctrl  = bus.ex_alu_ctrl;
      p.src_pc    = bus.ex_src_pc;
      p.src_imm   = bus.ex_src_imm;
      p.imm       = bus.ex_imm;
      p.rs1       = bus.ex_rs1;
      p.rs2       = bus.ex_rs2;
      p.rd        = bus.ex_rd;
      p.reg_write = bus.ex_reg_write;
      p.illegal   = bus.ex_illegal;
      return p;
   endfunction

   task automatic chk_bit(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_pay(input string nm, input idex_t act, input idex_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {%s} want {%s} (t=%0t)", nm, fmt(act), fmt(exp), $time);
      end
   endtask

   // Reference model of ex_valid and the scoreboard push on accepted instructions.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         sbq.delete();
      end else if (bus.flush) begin
         if (m_valid && !bus.ex_ready && sbq.size() > 0) void'(sbq.pop_front());
         m_valid <= 1'b0;
      end else if (!m_valid || bus.ex_ready) begin
         if (bus.if_valid) begin
            m_valid <= 1'b1;
            sbq.push_back('{e: exp_cur, name: name_cur});
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

   // Monitor: compares the held payload every cycle and retires it when EX consumes it.
   always @(negedge clk) begin
      if (!rst) begin
         chk_bit("if_ready", bus.if_ready, !m_valid || bus.ex_ready);
         chk_bit("ex_valid", bus.ex_valid, m_valid);
         if (m_valid) begin
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_empty: got ex_valid=1, want a queued expectation");
            end else begin
               chk_pay(sbq[0].name, actual(), sbq[0].e);
               if (bus.ex_ready) void'(sbq.pop_front());
            end
         end else begin
            chk_pay("bubble_clear", actual(), zero_p);
         end
      end
   end

   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input idex_t e, input string nm, input logic rdy, input logic fl);
      idex_t ee;
      ee           = e;
      ee.pc        = pc;
      exp_cur      = ee;
      name_cur     = nm;
      bus.if_valid = v;
      bus.if_instr = ins;
      bus.if_pc    = pc;
      bus.ex_ready = rdy;
      bus.flush    = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idex_t e_add;
      idex_t e_sub;
      n_tests  = 0;
      n_fail   = 0;
      zero_p   = mk(ALU_ADD, 0, 0, 32'h0, 0, 0, 0, 0, 0);
      e_add    = mk(ALU_ADD, 0, 0, 32'h0, 1, 2, 3, 1, 0);
      e_sub    = mk(ALU_SUB, 0, 0, 32'h0, 6, 7, 5, 1, 0);
      exp_cur  = zero_p;
      name_cur = "none";

      vecs.push_back('{32'h002081B3, e_add, "add"});
      vecs.push_back('{32'h407302B3, e_sub, "sub"});
      vecs.push_back('{32'h4030D093, mk(ALU_SRA, 0, 1, 32'h3, 1, 3, 1, 1, 0), "srai"});
      vecs.push_back('{32'h12345537, mk(ALU_LUI, 0, 1, 32'h12345000, 8, 3, 10, 1, 0), "lui"});
      vecs.push_back('{32'hFFF00093, mk(ALU_ADD, 0, 1, 32'hFFFFFFFF, 0, 31, 1, 1, 0), "addi_m1"});
      vecs.push_back('{32'h00000000, mk(ALU_ADD, 0, 0, 32'h0, 0, 0, 0, 0, 1), "zero_word"});
      vecs.push_back('{32'h00100013, mk(ALU_ADD, 0, 1, 32'h1, 0, 1, 0, 0, 0), "addi_x0"});
      vecs.push_back('{32'h80000117, mk(ALU_ADD, 1, 1, 32'h80000000, 0, 0, 2, 1, 0), "auipc"});
      vecs.push_back('{32'hFE20AE23, mk(ALU_ADD, 0, 1, 32'hFFFFFFFC, 1, 2, 28, 0, 0), "sw"});
      vecs.push_back('{32'h00208463, mk(ALU_SUB, 0, 0, 32'h8, 1, 2, 8, 0, 0), "beq"});
      vecs.push_back('{32'hFE41EFE3, mk(ALU_SLTU, 0, 0, 32'hFFFFFFFE, 3, 4, 31, 0, 0), "bltu"});
      vecs.push_back('{32'h001000EF, mk(ALU_ADD, 1, 1, 32'h800, 0, 1, 1, 1, 0), "jal"});
      vecs.push_back('{32'h00008067, mk(ALU_ADD, 0, 1, 32'h0, 1, 0, 0, 0, 0), "jalr_x0"});
      vecs.push_back('{32'h4020F1B3, mk(ALU_ADD, 0, 0, 32'h0, 1, 2, 3, 0, 1), "op_f7_bad"});
      vecs.push_back('{32'h40109093, mk(ALU_ADD, 0, 0, 32'h0, 1, 1, 1, 0, 1), "slli_f7_bad"});
      vecs.push_back('{32'h01012283, mk(ALU_ADD, 0, 1, 32'h10, 2, 16, 5, 1, 0), "lw"});
      vecs.push_back('{32'h0020A463, mk(ALU_ADD, 0, 0, 32'h0, 1, 2, 8, 0, 1), "br_f3_bad"});
      vecs.push_back('{32'h0020A233, mk(ALU_SLT, 0, 0, 32'h0, 1, 2, 4, 1, 0), "slt"});
      vecs.push_back('{32'h4020D1B3, mk(ALU_SRA, 0, 0, 32'h0, 1, 2, 3, 1, 0), "sra"});

      rst          = 1'b1;
      bus.if_valid = 1'b0;
      bus.if_instr = 32'h0;
      bus.if_pc    = 32'h0;
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b1;
      #1;
      chk_bit("reset_ex_valid", bus.ex_valid, 1'b0);
      chk_bit("reset_if_ready", bus.if_ready, 1'b1);
      chk_pay("reset_payload", actual(), zero_p);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Back-to-back directed vectors.
      for (int i = 0; i < vecs.size(); i++) begin
         cyc(1'b1, vecs[i].ins, 32'h100 + 32'(i) * 4, vecs[i].e, vecs[i].name, 1'b1, 1'b0);
      end
      cyc(1'b0, 32'h0, 32'h0, zero_p, "idle", 1'b1, 1'b0);

      // Stall: add held for three cycles while sub waits, then sub loads on release.
      cyc(1'b1, 32'h002081B3, 32'h200, e_add, "stall_add", 1'b1, 1'b0);
      repeat (3) cyc(1'b1, 32'h407302B3, 32'h204, e_sub, "stall_sub", 1'b0, 1'b0);
      cyc(1'b1, 32'h407302B3, 32'h204, e_sub, "stall_sub", 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, zero_p, "idle", 1'b1, 1'b0);

      // Flush drops the incoming instruction, and kills a stalled one.
      cyc(1'b1, 32'h12345537, 32'h300, zero_p, "flush_drop", 1'b1, 1'b1);
      cyc(1'b1, 32'h002081B3, 32'h304, e_add, "flush_pre", 1'b1, 1'b0);
      cyc(1'b1, 32'h407302B3, 32'h308, e_sub, "flush_stall", 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 32'h0, zero_p, "idle", 1'b1, 1'b0);

      // Asynchronous reset mid-stall clears the stage before the next clock edge.
      cyc(1'b1, 32'h002081B3, 32'h400, e_add, "rst_add", 1'b1, 1'b0);
      bus.if_valid = 1'b0;
      bus.ex_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk_bit("rst_stall_ex_valid", bus.ex_valid, 1'b0);
      chk_pay("rst_stall_payload", actual(), zero_p);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;

      repeat (2) cyc(1'b0, 32'h0, 32'h0, zero_p, "drain", 1'b1, 1'b0);
      n_tests++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending, want 0", sbq.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
